// File: rtl/data_upload.sv
// data_upload: SPI upload responder; streams a RAM buffer, or its size, to the io controller on sdo.
// Latency: SPI actions land one clk after the synchronised sck edge is seen; at most one RAM read in flight.
// Backpressure: none on SPI; a byte due before its RAM data arrives goes out as 0xFF and sets underrun.
module data_upload #(
  parameter logic [24:0] BASE_ADDR   = 25'h200000,
  parameter logic [7:0]  CMD_RX      = 8'h56,
  parameter logic [7:0]  CMD_RX_DAT  = 8'h57,
  parameter logic [7:0]  CMD_RX_SIZE = 8'h58
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        ss,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  input  logic [24:0] size,
  output logic        uploading,
  output logic        underrun,
  output logic        mem_rd,
  output logic [24:0] mem_a,
  input  logic [7:0]  mem_q,
  input  logic        mem_ack
);
  typedef enum logic {F_IDLE, F_WAIT} fetch_state_t;

  logic [1:0]   sck_sync, ss_sync, sdi_sync;
  logic         sck_dly;
  logic         sck_s, ss_s, sdi_s, sck_rise, sck_fall;
  logic [3:0]   cnt;
  logic [6:0]   rx_sr;
  logic [7:0]   cmd;
  logic [24:0]  size_snap;
  logic [31:0]  size_word;
  logic [2:0]   size_idx;
  logic [7:0]   shifter;
  logic [24:0]  pointer;
  logic [24:0]  fetch_ptr;
  logic [7:0]   buf_dat;
  logic         buf_vld;
  logic         drop;
  fetch_state_t fstate, fstate_nxt;
  logic         launch;
  logic         start_evt, stop_evt, ctl_evt, load_evt, tx_cmd;
  logic [7:0]   load_byte;
  logic         take_buf, set_underrun, adv_ptr;

  // Two-stage synchronisers for the SPI pins plus one extra sck stage for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync <= 2'b00;
      ss_sync  <= 2'b11;
      sdi_sync <= 2'b00;
      sck_dly  <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], sck};
      ss_sync  <= {ss_sync[0], ss};
      sdi_sync <= {sdi_sync[0], sdi};
      sck_dly  <= sck_sync[1];
    end
  end

  assign sck_s    = sck_sync[1];
  assign ss_s     = ss_sync[1];
  assign sdi_s    = sdi_sync[1];
  assign sck_rise = sck_s & ~sck_dly;
  assign sck_fall = ~sck_s & sck_dly;

  // Control command completes on the last payload bit; bit 0 selects start or stop.
  assign start_evt = sck_rise && !ss_s && (cnt == 4'd15) && (cmd == CMD_RX) && sdi_s;
  assign stop_evt  = sck_rise && !ss_s && (cnt == 4'd15) && (cmd == CMD_RX) && !sdi_s;
  assign ctl_evt   = start_evt || stop_evt;
  // Byte boundary on the falling edge: cnt is 8 right after the command byte and after each wrap.
  assign load_evt  = sck_fall && !ss_s && cnt[3] && (cnt[2:0] == 3'd0);
  assign tx_cmd    = (cmd == CMD_RX_DAT) || (cmd == CMD_RX_SIZE);

  // Bit counter, receive shifter and command latch; the size is frozen with the command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 4'd0;
      rx_sr     <= 7'd0;
      cmd       <= 8'd0;
      size_snap <= 25'd0;
    end else if (ss_s) begin
      cnt <= 4'd0;
    end else if (sck_rise) begin
      rx_sr <= {rx_sr[5:0], sdi_s};
      cnt   <= (cnt == 4'd15) ? 4'd8 : cnt + 4'd1;
      if (cnt == 4'd7) begin
        cmd       <= {rx_sr, sdi_s};
        size_snap <= size;
      end
    end
  end

  assign size_word = {7'd0, size_snap};

  // Choose the next byte to transmit and what loading it does to the session state.
  always_comb begin
    load_byte    = 8'h00;
    take_buf     = 1'b0;
    set_underrun = 1'b0;
    adv_ptr      = 1'b0;
    if (cmd == CMD_RX_DAT) begin
      if (!uploading) begin
        load_byte = 8'hFF;
      end else begin
        adv_ptr = 1'b1;
        if (pointer >= size) begin
          load_byte = 8'h00;
        end else if (buf_vld) begin
          load_byte = buf_dat;
          take_buf  = 1'b1;
        end else begin
          load_byte    = 8'hFF;
          set_underrun = 1'b1;
        end
      end
    end else if (cmd == CMD_RX_SIZE) begin
      case (size_idx)
        3'd0:    load_byte = size_word[31:24];
        3'd1:    load_byte = size_word[23:16];
        3'd2:    load_byte = size_word[15:8];
        3'd3:    load_byte = size_word[7:0];
        default: load_byte = 8'h00;
      endcase
    end
  end

  // Transmit shifter: load at byte boundaries, otherwise shift MSB-first on each sck fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shifter  <= 8'd0;
      size_idx <= 3'd0;
    end else if (sck_rise && !ss_s && (cnt == 4'd7)) begin
      size_idx <= 3'd0;
    end else if (sck_fall && !ss_s) begin
      if (load_evt) begin
        shifter <= load_byte;
        if (size_idx != 3'd4) size_idx <= size_idx + 3'd1;
      end else begin
        shifter <= {shifter[6:0], 1'b0};
      end
    end
  end

  assign sdo_oe = !ss_s && cnt[3] && tx_cmd;
  assign sdo    = sdo_oe & shifter[7];

  // Session flags and the send pointer, which saturates rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uploading <= 1'b0;
      underrun  <= 1'b0;
      pointer   <= 25'd0;
    end else if (start_evt) begin
      uploading <= 1'b1;
      underrun  <= 1'b0;
      pointer   <= 25'd0;
    end else if (stop_evt) begin
      uploading <= 1'b0;
    end else if (load_evt) begin
      if (adv_ptr && (pointer != '1)) pointer <= pointer + 25'd1;
      if (set_underrun) underrun <= 1'b1;
    end
  end

  // One-byte prefetch buffer; a read in flight across start/stop is completed but its data dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_dat   <= 8'd0;
      buf_vld   <= 1'b0;
      fetch_ptr <= 25'd0;
      drop      <= 1'b0;
    end else if (ctl_evt) begin
      if (start_evt) begin
        buf_vld   <= 1'b0;
        fetch_ptr <= 25'd0;
      end
      drop <= (fstate == F_WAIT) && !mem_ack;
    end else if ((fstate == F_WAIT) && mem_ack) begin
      drop <= 1'b0;
      if (!drop) begin
        buf_dat   <= mem_q;
        buf_vld   <= 1'b1;
        fetch_ptr <= fetch_ptr + 25'd1;
      end
    end else if (load_evt && take_buf) begin
      buf_vld <= 1'b0;
    end
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fstate <= F_IDLE;
    else       fstate <= fstate_nxt;
  end

  // Fetch FSM next state: issue a read whenever the buffer is empty and bytes remain.
  always_comb begin
    fstate_nxt = fstate;
    launch     = 1'b0;
    case (fstate)
      F_IDLE: begin
        // Hold off while start/stop is rewriting fetch_ptr so the address is never stale.
        if (uploading && !buf_vld && (fetch_ptr < size) && !ctl_evt) begin
          fstate_nxt = F_WAIT;
          launch     = 1'b1;
        end
      end
      F_WAIT: begin
        if (mem_ack) fstate_nxt = F_IDLE;
      end
      default: fstate_nxt = F_IDLE;
    endcase
  end

  // Read request: raised with a stable address on launch, dropped only by the acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rd <= 1'b0;
      mem_a  <= BASE_ADDR;
    end else if (launch) begin
      mem_rd <= 1'b1;
      mem_a  <= BASE_ADDR + fetch_ptr;
    end else if ((fstate == F_WAIT) && mem_ack) begin
      mem_rd <= 1'b0;
    end
  end

endmodule
